// File: rtl/next_pc_unit.sv
//------------------------------------------------------------------------------
// Module      : next_pc_unit
// Description : Fetch-stage PC register with next-PC selection (seq, branch,
//               J/JAL, JR, exception) and an advisory return-address stack.
//               Optional macro MISALIGN_TRAP_EN traps misaligned JR targets.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module next_pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INDEX_W   = 26,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         exc,
    input  logic [ADDR_W-1:0]            id_pc,
    input  logic                         br_taken,
    input  logic [15:0]                  br_off,
    input  logic                         j_en,
    input  logic                         jal,
    input  logic [INDEX_W-1:0]           j_index,
    input  logic                         jr_en,
    input  logic [ADDR_W-1:0]            jr_target,
    input  logic                         jr_ra,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus4,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic                         misalign
);

    localparam int                  c_PTR_W = $clog2(RAS_DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0]   c_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  w_id_p4;
    logic [ADDR_W-1:0]  w_br_target;
    logic [ADDR_W-1:0]  w_j_target;
    logic [ADDR_W-1:0]  w_jr_target;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_push_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic               r_unf;
    logic               w_ras_full;
    logic               w_ras_empty;

    assign w_id_p4     = id_pc + ADDR_W'(4);
    assign w_br_target = w_id_p4 + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
    assign w_j_target  = {w_id_p4[ADDR_W-1:INDEX_W+2], j_index, 2'b00};
    assign w_jr_target = jr_target & c_WORD_MASK;

    assign w_ras_full  = (r_count == c_FULL);
    assign w_ras_empty = (r_count == '0);
    assign w_push_ptr  = r_ptr + c_PTR_W'(1);

`ifdef MISALIGN_TRAP_EN
    logic w_mis;
    logic r_misalign;
    logic w_jr_misaligned;

    assign w_jr_misaligned = |jr_target[1:0];
    assign misalign        = r_misalign;
`else
    assign misalign        = 1'b0;
`endif

    // Priority: exc > stall > jr > j > branch > sequential.
    always_comb begin
        w_pc_next = r_pc + ADDR_W'(4);
        w_push    = 1'b0;
        w_pop     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_mis     = 1'b0;
`endif
        if (exc) begin
            w_pc_next = EXC_VEC;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (jr_en) begin
`ifdef MISALIGN_TRAP_EN
            if (w_jr_misaligned) begin
                w_pc_next = EXC_VEC;
                w_mis     = 1'b1;
            end else begin
                w_pc_next = w_jr_target;
                w_pop     = jr_ra;
            end
`else
            w_pc_next = w_jr_target;
            w_pop     = jr_ra;
`endif
        end else if (j_en) begin
            w_pc_next = w_j_target;
            w_push    = jal;
        end else if (br_taken) begin
            w_pc_next = w_br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (exc) begin
                r_count <= '0;
            end else if (w_push) begin
                // When full the next slot holds the oldest entry, so the
                // pointer still advances and the oldest is overwritten.
                r_ptr <= w_push_ptr;
                if (w_ras_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (w_pop) begin
                if (w_ras_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_ptr   <= r_ptr - c_PTR_W'(1);
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_push_ptr] <= id_pc + ADDR_W'(8);
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_mis;
        end
    end
`endif

    assign pc        = r_pc;
    assign pc_plus4  = r_pc + ADDR_W'(4);
    assign ras_top   = w_ras_empty ? '0 : r_ras[r_ptr];
    assign ras_count = r_count;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule

`default_nettype wire
